qr_stage_sequencer: RTL

- Controls one QR frame at a time through the unmask stage and then the codeword-decode stage.
- Latches each incoming downsampled 21x21 grid and holds it stable for the unmask stage.
- Pulses a synchronous clear into both stages before every frame, because both stages park in a finished state after a run.
- Latches the unmasked grid, starts decode, and reports one result per accepted frame. Timeouts and frames dropped while busy are counted and flagged.

---
 rtl/qr_stage_sequencer.sv | 88 ++++++++
 1 files changed

// File: rtl/qr_stage_sequencer.sv
// qr_stage_sequencer: runs one QR frame through the unmask stage and then the decode stage
// Ports: clk_in/rst_in clock and async reset; qr_valid_in/grid_in incoming frame;
// stage_clr_out/start_unmask_out/qr_grid_out drive the unmask stage; unmask_ready_in/unmasked_in return from it;
// start_decode_out/unmasked_out drive the decode stage; decode_done_in/decode_ok_in return from it;
// result_valid_out/result_ok_out/timeout_out report each frame; busy_out and drop_count_out show refusals.
module qr_stage_sequencer #(
  parameter int MOD_SIZE = 21,
  parameter int UM_TIMEOUT = 1024,
  parameter int DEC_TIMEOUT = 4096
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           qr_valid_in,
  input  logic [MOD_SIZE*MOD_SIZE-1:0]   grid_in,
  output logic                           stage_clr_out,
  output logic                           start_unmask_out,
  output logic [MOD_SIZE*MOD_SIZE-1:0]   qr_grid_out,
  input  logic                           unmask_ready_in,
  input  logic [MOD_SIZE*MOD_SIZE-1:0]   unmasked_in,
  output logic                           start_decode_out,
  output logic [MOD_SIZE*MOD_SIZE-1:0]   unmasked_out,
  input  logic                           decode_done_in,
  input  logic                           decode_ok_in,
  output logic                           result_valid_out,
  output logic                           result_ok_out,
  output logic [1:0]                     timeout_out,
  output logic                           busy_out,
  output logic [7:0]                     drop_count_out
);
  localparam int CW = $clog2(UM_TIMEOUT > DEC_TIMEOUT ? UM_TIMEOUT : DEC_TIMEOUT);
  typedef enum logic [2:0] {IDLE, CLR, START_UM, WAIT_UM, START_DEC, WAIT_DEC, REPORT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic um_exp, dec_exp;
  assign um_exp = cnt == CW'(UM_TIMEOUT - 1);
  assign dec_exp = cnt == CW'(DEC_TIMEOUT - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = qr_valid_in ? CLR : IDLE;
      CLR:       state_n = START_UM;
      START_UM:  state_n = WAIT_UM;
      WAIT_UM:   state_n = unmask_ready_in ? START_DEC : um_exp ? REPORT : WAIT_UM;
      START_DEC: state_n = WAIT_DEC;
      WAIT_DEC:  state_n = (decode_done_in || dec_exp) ? REPORT : WAIT_DEC;
      default:   state_n = IDLE;
    endcase
  end
  // Pulses and busy are registered from the next state so each lines up with its state's cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt <= '0;
      stage_clr_out <= 1'b0;
      start_unmask_out <= 1'b0;
      start_decode_out <= 1'b0;
      result_valid_out <= 1'b0;
      busy_out <= 1'b0;
      qr_grid_out <= '0;
      unmasked_out <= '0;
      result_ok_out <= 1'b0;
      timeout_out <= 2'b00;
      drop_count_out <= 8'd0;
    end else begin
      state <= state_n;
      cnt <= (state == WAIT_UM || state == WAIT_DEC) ? cnt + CW'(1) : '0;
      stage_clr_out <= state_n == CLR;
      start_unmask_out <= state_n == START_UM;
      start_decode_out <= state_n == START_DEC;
      result_valid_out <= state_n == REPORT;
      busy_out <= state_n != IDLE;
      if (state == IDLE && qr_valid_in) qr_grid_out <= grid_in;
      if (state != IDLE && qr_valid_in && drop_count_out != 8'hff) drop_count_out <= drop_count_out + 8'd1;
      if (state == WAIT_UM && unmask_ready_in) unmasked_out <= unmasked_in;
      if (state == WAIT_UM && !unmask_ready_in && um_exp) begin
        result_ok_out <= 1'b0;
        timeout_out <= 2'b01;
      end
      if (state == WAIT_DEC && decode_done_in) begin
        result_ok_out <= decode_ok_in;
        timeout_out <= 2'b00;
      end else if (state == WAIT_DEC && dec_exp) begin
        result_ok_out <= 1'b0;
        timeout_out <= 2'b10;
      end
    end
  end
endmodule
